// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning slice.
// Channel indices follow the board wiring of the raw button bus.
package btn_pkg;

  localparam int N_BTN = 5;

  localparam int BTN_C = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_U = 4;

  // Defaults assume a 100 MHz clock: 10 ms debounce, 300 ms first repeat, 50 ms cadence.
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 30000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, debounce counter and auto-repeat FSM.
// All outputs come straight from flops.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_step
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          step_q, step_d;
  rpt_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  // Next-state logic for synchroniser, debounce and repeat FSM.
  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    level_d   = level_q;
    dcnt_d    = {DW{1'b0}};
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;
    state_d   = state_q;
    rcnt_d    = rcnt_q;

    // Any sample matching the current level restarts the stability count.
    if (s2_q == level_q) begin
      dcnt_d = {DW{1'b0}};
    end else if (dcnt_q == DB_LAST) begin
      level_d   = s2_q;
      dcnt_d    = {DW{1'b0}};
      press_d   = s2_q;
      release_d = ~s2_q;
    end else begin
      dcnt_d = dcnt_q + {{(DW-1){1'b0}}, 1'b1};
    end

    // A release wins over a coincident repeat step.
    if (release_d) begin
      state_d = IDLE;
      rcnt_d  = {RW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          rcnt_d = {RW{1'b0}};
          if (press_d) begin
            step_d  = 1'b1;
            state_d = DELAY;
          end else begin
            state_d = IDLE;
          end
        end
        DELAY: begin
          if (rcnt_q == RD_LAST) begin
            step_d  = 1'b1;
            rcnt_d  = {RW{1'b0}};
            state_d = REPEAT;
          end else begin
            rcnt_d = rcnt_q + {{(RW-1){1'b0}}, 1'b1};
          end
        end
        REPEAT: begin
          if (rcnt_q == RP_LAST) begin
            step_d = 1'b1;
            rcnt_d = {RW{1'b0}};
          end else begin
            rcnt_d = rcnt_q + {{(RW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = {RW{1'b0}};
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      dcnt_q    <= {DW{1'b0}};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      state_q   <= IDLE;
      rcnt_q    <= {RW{1'b0}};
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_step    = step_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions every board push-button with an independent btn_channel.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = btn_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_step
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g]),
      .btn_step   (btn_step[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: hand-derived vector table, corner sequences and
// randomized bouncing buttons checked against a behavioural model.
module tb_btn_conditioner;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw, btn_level, btn_press, btn_release, btn_step;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_step(btn_step)
  );

  // Behavioural model: raw reaches the debouncer two edges late; a change is
  // accepted at the DB-th consecutive differing sample; steps occur at press
  // age 0, RD, RD+RP, RD+2RP, ... while held.
  logic         m_p1[N], m_p2[N], m_lvl[N], m_held[N];
  int           m_run[N], m_tp[N];
  logic [N-1:0] e_level, e_press, e_release, e_step;

  task automatic model_edge();
    cyc++;
    e_press = '0; e_release = '0; e_step = '0;
    for (int c = 0; c < N; c++) begin
      logic s;
      int   age;
      if (!rst) begin
        m_p1[c] = 1'b0; m_p2[c] = 1'b0; m_lvl[c] = 1'b0; m_held[c] = 1'b0; m_run[c] = 0;
      end else begin
        s = m_p2[c];
        m_p2[c] = m_p1[c];
        m_p1[c] = btn_raw[c];
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_run[c] = 0;
            m_lvl[c] = s;
            if (s) begin e_press[c] = 1'b1; m_held[c] = 1'b1; m_tp[c] = cyc; end
            else   begin e_release[c] = 1'b1; m_held[c] = 1'b0; end
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_held[c]) begin
          age = cyc - m_tp[c];
          if (age == 0 || (age >= RD && (age - RD) % RP == 0)) e_step[c] = 1'b1;
        end
      end
      e_level[c] = m_lvl[c];
    end
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_level", btn_level, e_level);
    chk("model_press", btn_press, e_press);
    chk("model_release", btn_release, e_release);
    chk("model_step", btn_step, e_step);
  endtask

  typedef struct {
    logic [N-1:0] raw, level, press, rel, step;
  } vec_t;
  vec_t tbl[29];

  logic [N-1:0] want = '0;
  int           pe, found, nrel;
  logic [N-1:0] got;

  initial begin
    // Clean press on channel 2, auto-repeat at 5,15,18,21,24, release raw at 22
    // is accepted at 27 where the would-be repeat step is suppressed.
    for (int e = 0; e < 29; e++) begin
      tbl[e].raw   = (e < 22) ? 5'b00100 : 5'b00000;
      tbl[e].level = (e >= 5 && e < 27) ? 5'b00100 : 5'b00000;
      tbl[e].press = (e == 5) ? 5'b00100 : 5'b00000;
      tbl[e].rel   = (e == 27) ? 5'b00100 : 5'b00000;
      tbl[e].step  = (e == 5 || e == 15 || e == 18 || e == 21 || e == 24) ? 5'b00100 : 5'b00000;
    end

    rst = 1'b0; btn_raw = '0;
    tick(); tick();
    chk("reset_outs", btn_level | btn_press | btn_release | btn_step, 5'b00000);
    rst = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 29; i++) begin
      btn_raw = tbl[i].raw;
      tick();
      chk("tbl_level", btn_level, tbl[i].level);
      chk("tbl_press", btn_press, tbl[i].press);
      chk("tbl_release", btn_release, tbl[i].rel);
      chk("tbl_step", btn_step, tbl[i].step);
    end
    repeat (2) tick();

    // Glitch: three high samples on channel 1 never reach the level.
    btn_raw = 5'b00010;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) btn_raw = 5'b00000;
      tick();
      chk("glitch_quiet", btn_level | btn_press | btn_step, 5'b00000);
    end

    // Release bounce on channel 0 while repeating.
    btn_raw = 5'b00001;
    for (int i = 0; i < 10 && !btn_press[0]; i++) tick();
    chk("bounce_press", btn_press, 5'b00001);
    pe = cyc;
    while (cyc < pe + 12) tick();
    btn_raw = 5'b00000;
    tick(); tick();
    btn_raw = 5'b00001;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("bounce_level", btn_level, 5'b00001);
      chk("bounce_step", btn_step, ((cyc - pe - RD) % RP == 0) ? 5'b00001 : 5'b00000);
    end
    btn_raw = 5'b00000;
    nrel = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (btn_release[0]) nrel++;
    end
    chk("release_count", N'(nrel), 5'd1);

    // Simultaneous presses on right and up.
    btn_raw = 5'b11000; found = -1; got = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (btn_press != '0 && found < 0) begin found = i; got = btn_press; end
    end
    chk("simul_press", got, 5'b11000);
    chk("simul_edge", N'(found), 5'd5);
    btn_raw = 5'b00000;
    repeat (8) tick();

    // Reset during DELAY with channel 2 held.
    btn_raw = 5'b00100;
    for (int i = 0; i < 10 && !btn_press[2]; i++) tick();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_outs", btn_level | btn_press | btn_release | btn_step, 5'b00000);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_repress", btn_press, (i == 5) ? 5'b00100 : 5'b00000);
    end
    btn_raw = 5'b00000;
    repeat (8) tick();

    // Randomized bouncing buttons with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(59, 0) == 0) want[c] = ~want[c];
        btn_raw[c] = ($urandom_range(11, 0) == 0) ? ~want[c] : want[c];
      end
      rst = ($urandom_range(699, 0) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input conditioning stage between the raw board push-buttons and the game logic. It synchronises, debounces and edge-detects each button. Per button it provides a clean held level, one-cycle press and release pulses, and a one-cycle step strobe that auto-repeats while the button is held. The game logic consumes btn_level for reset and btn_step for block movement in place of the raw btn bus.

## Interface
- N_BTN, 5, number of button channels (bit 0 = centre/reset, 1 = down, 2 = left, 3 = right, 4 = up)
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a change (10 ms at 100 MHz); minimum 2
- REPEAT_DELAY, 30000000, cycles from press pulse to first auto-repeat step; minimum 2
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps; minimum 2

- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, synchronous, active-low
- btn_raw  in  N_BTN  asynchronous button pins
- btn_level  out  N_BTN  debounced level
- btn_press  out  N_BTN  one-cycle pulse on accepted 0→1
- btn_release  out  N_BTN  one-cycle pulse on accepted 1→0
- btn_step  out  N_BTN  one-cycle pulse on press and on each auto-repeat

## Operation
- All channels are identical and independent. Simultaneous activity on several channels is processed in parallel with no priority.
- Synchroniser: two flops per channel, s1 ← btn_raw, s2 ← s1. Both reset to 0.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES).
  - s2 == btn_level: count ← 0.
  - s2 != btn_level and count == DEBOUNCE_CYCLES−1: btn_level ← s2, count ← 0, and the matching press or release pulse is registered on the same edge.
  - Otherwise: count ← count+1.
- Glitch handling: any single sample of s2 equal to btn_level clears the count. A partial glitch never changes the level.
- Per-channel repeat FSM:
  - States: IDLE, DELAY, REPEAT. Repeat counter width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
  - IDLE → DELAY on the accepted press. btn_step pulses on that same edge; rcnt ← 0.
  - DELAY: rcnt increments each cycle. At rcnt == REPEAT_DELAY−1: step pulse, rcnt ← 0, → REPEAT.
  - REPEAT: at rcnt == REPEAT_PERIOD−1: step pulse, rcnt ← 0, stay in REPEAT.
  - Accepted release in any state → IDLE, rcnt ← 0, no step pulse on that edge.
- Outputs are registered. Pulses are exactly one cycle wide.
- btn_press and btn_release never assert in the same cycle on one channel.

## Timing
- Reset (rst low at an edge): s1, s2, btn_level, all counters, btn_press, btn_release and btn_step become 0. The FSM goes to IDLE.
- Reset mid-debounce or mid-repeat aborts the operation with no pulse emitted.
- Latency: let edge k be the first edge at which s1 samples the new raw value, with the raw value stable afterwards. btn_level and the press/release pulse (and the step pulse on a press) appear after edge k+1+DEBOUNCE_CYCLES.
- First auto-repeat step: REPEAT_DELAY cycles after the press pulse. Later steps: every REPEAT_PERIOD cycles.
- Button held through reset: the first edge with rst high acts as edge k, so the press appears after edge k+1+DEBOUNCE_CYCLES.
- Counters never wrap. They are bounded by the equality compares above.

## Structure
- Package btn_pkg holds:
  - the N_BTN constant and button index constants BTN_C, BTN_D, BTN_L, BTN_R, BTN_U;
  - the default cycle constants;
  - the enumerated repeat state type (IDLE, DELAY, REPEAT).
- Sub-module btn_channel contains the synchroniser, debounce counter and repeat FSM for one button.
- btn_conditioner instantiates btn_channel N_BTN times with a generate loop and contains no other logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: btn_raw[2] 0→1 before edge 0 → btn_level[2], btn_press[2] and btn_step[2] high after edge 5. Pulses low again after edge 6.
- Glitch rejection: btn_raw[1] high for 3 cycles, then low → btn_level, btn_press and btn_step stay 0 throughout.
- Auto-repeat: press at edge 5 as above, held → btn_step[2] pulses after edges 5, 15, 18, 21, …. Release accepted → no further steps and a single btn_release[2] pulse.
- Release bounce: held button toggles low for 2 cycles then high → btn_level stays 1 and the repeat cadence is unchanged.
- Simultaneous buttons: btn_raw[3] and btn_raw[4] rise before the same edge → identical, coincident press pulses; the other channels stay quiet.
- Reset mid-operation: rst low for 1 cycle during DELAY with the button held → all outputs 0 after that edge. btn_press reasserts 5 edges after the first edge with rst high, i.e. after edge k+1+DEBOUNCE_CYCLES with k that edge.
